// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports,
// optional same-cycle write forwarding and a per-register pending scoreboard.
module regfile_mp #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 4,
  parameter int                NUM_REGS  = 16,
  parameter int                NUM_RD    = 3,
  parameter int                BYPASS    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 w_en,
  input  logic [2*ADDR_W-1:0]        w_addr,
  input  logic [2*DATA_W-1:0]        w_data,
  input  logic [NUM_RD*ADDR_W-1:0]   r_addr,
  output logic [NUM_RD*DATA_W-1:0]   r_data,
  input  logic                       lock_en,
  input  logic [ADDR_W-1:0]          lock_addr,
  output logic [NUM_RD-1:0]          r_busy,
  output logic [NUM_REGS-1:0]        pending
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Port 1 is applied after port 0 so it wins a same-address collision;
  // the lock is applied last so a newly issued producer keeps the register pending.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    for (int p = 0; p < 2; p++) begin
      if (w_en[p]) begin
        for (int n = 0; n < NUM_REGS; n++) begin
          if (w_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(n)) begin
            regs_d[n]    = w_data[p*DATA_W +: DATA_W];
            pending_d[n] = 1'b0;
          end
        end
      end
    end
    for (int n = 0; n < NUM_REGS; n++) begin
      if (lock_en && (lock_addr == ADDR_W'(n))) pending_d[n] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= RESET_VAL;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              in_range;
    logic              pend_bit;
    logic              wh0;
    logic              wh1;
    logic [DATA_W-1:0] stored;

    assign ra = r_addr[k*ADDR_W +: ADDR_W];

    // Addresses that match no implemented register leave in_range low, yielding 0.
    always_comb begin
      in_range = 1'b0;
      stored   = '0;
      pend_bit = 1'b0;
      for (int n = 0; n < NUM_REGS; n++) begin
        if (ra == ADDR_W'(n)) begin
          in_range = 1'b1;
          stored   = regs_q[n];
          pend_bit = pending_q[n];
        end
      end
    end

    assign wh0 = rst_n && w_en[0] && in_range && (w_addr[0 +: ADDR_W] == ra);
    assign wh1 = rst_n && w_en[1] && in_range && (w_addr[ADDR_W +: ADDR_W] == ra);

    assign r_data[k*DATA_W +: DATA_W] =
      ((BYPASS != 0) && wh1) ? w_data[DATA_W +: DATA_W] :
      ((BYPASS != 0) && wh0) ? w_data[0 +: DATA_W] : stored;

    assign r_busy[k] = pend_bit && !((BYPASS != 0) && (wh0 || wh1));
  end

endmodule
